sec100_down: RTL

Two-digit BCD countdown timer for the seconds-display board. It counts from a loaded preset (00–99) down to 00 at one count per second, derived from the 50 MHz board clock. It drives the same pair of 7-segment digits as the up-counting seconds display, and flags expiry with a one-cycle borrow pulse and a level `done` flag. It is the down-counting counterpart to the existing up counter and its carry output.

---
 rtl/sec100_down_if.sv | 23 ++
 rtl/sec100_down.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sec100_down_if.sv
// Bus bundle for the sec100_down countdown timer: control pulses,
// preset digits, and the borrow/done/segment outputs.
interface sec100_down_if;
    logic       load;
    logic [3:0] preset_high;
    logic [3:0] preset_low;
    logic       start;
    logic       stop;
    logic       bn;
    logic       done;
    logic [6:0] high_seg;
    logic [6:0] low_seg;

    modport master (
        output load, preset_high, preset_low, start, stop,
        input  bn, done, high_seg, low_seg
    );

    modport slave (
        input  load, preset_high, preset_low, start, stop,
        output bn, done, high_seg, low_seg
    );
endinterface

// File: rtl/sec100_down.sv
// Two-digit BCD countdown timer with 7-segment outputs.
// Optional SEC100_DOWN_BLINK_EN: blink the expired 00 display.
module sec100_down #(
    parameter int DIV_MAX = 50_000_000
) (
    input  logic         clk_50MHz,
    input  logic         clr,
    sec100_down_if.slave bus
);

    localparam int DW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        st, st_n;
    logic [3:0]    cnt_high, cnt_high_n;
    logic [3:0]    cnt_low, cnt_low_n;
    logic [DW-1:0] div, div_n;
    logic          bn_q, bn_n;
    logic          tick;
    logic          last;
    logic          zero;
`ifdef SEC100_DOWN_BLINK_EN
    logic          vis, vis_n;
`endif

    function automatic logic [3:0] clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign zero = (cnt_high == 4'd0) && (cnt_low == 4'd0);
    assign tick = (st == RUN) && (div == DIV_LAST);
    // Count 01 on a tick is the only way to land on 00.
    assign last = tick && (cnt_high == 4'd0) && (cnt_low == 4'd1);

    always_comb begin
        st_n       = st;
        cnt_high_n = cnt_high;
        cnt_low_n  = cnt_low;
        div_n      = div;
        bn_n       = 1'b0;
`ifdef SEC100_DOWN_BLINK_EN
        vis_n      = vis;
`endif
        if (bus.load) begin
            st_n       = IDLE;
            cnt_high_n = clamp(bus.preset_high);
            cnt_low_n  = clamp(bus.preset_low);
            div_n      = '0;
`ifdef SEC100_DOWN_BLINK_EN
            vis_n      = 1'b1;
`endif
        end else begin
            unique case (st)
                IDLE: begin
                    if (bus.start && !bus.stop && !zero) begin
                        st_n  = RUN;
                        div_n = '0;
                    end
                end
                RUN: begin
                    div_n = tick ? '0 : div + 1'b1;
                    if (tick) begin
                        if (cnt_low != 4'd0) begin
                            cnt_low_n = cnt_low - 4'd1;
                        end else begin
                            cnt_low_n  = 4'd9;
                            cnt_high_n = cnt_high - 4'd1;
                        end
                    end
                    // Expiry outranks a stop landing on the same edge.
                    if (last) begin
                        st_n = DONE;
                        bn_n = 1'b1;
`ifdef SEC100_DOWN_BLINK_EN
                        vis_n = 1'b1;
`endif
                    end else if (bus.stop) begin
                        st_n = PAUSE;
                    end
                end
                PAUSE: begin
                    if (bus.start && !bus.stop) begin
                        st_n = RUN;
                    end
                end
                DONE: begin
`ifdef SEC100_DOWN_BLINK_EN
                    div_n = (div == DIV_LAST) ? '0 : div + 1'b1;
                    if (div == DIV_LAST) begin
                        vis_n = !vis;
                    end
`endif
                end
                default: st_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!clr) begin
            st       <= IDLE;
            cnt_high <= 4'd0;
            cnt_low  <= 4'd0;
            div      <= '0;
            bn_q     <= 1'b0;
`ifdef SEC100_DOWN_BLINK_EN
            vis      <= 1'b1;
`endif
        end else begin
            st       <= st_n;
            cnt_high <= cnt_high_n;
            cnt_low  <= cnt_low_n;
            div      <= div_n;
            bn_q     <= bn_n;
`ifdef SEC100_DOWN_BLINK_EN
            vis      <= vis_n;
`endif
        end
    end

    assign bus.bn   = bn_q;
    assign bus.done = (st == DONE);

`ifdef SEC100_DOWN_BLINK_EN
    assign bus.high_seg = (st == DONE && !vis) ? 7'h00 : seg7(cnt_high);
    assign bus.low_seg  = (st == DONE && !vis) ? 7'h00 : seg7(cnt_low);
`else
    assign bus.high_seg = seg7(cnt_high);
    assign bus.low_seg  = seg7(cnt_low);
`endif

endmodule
